// File: rtl/column_drop_if.sv
// Connect-4 drop engine bus: move requests in, move responses and board state out.
//   master: game controller side (drives clear/move_valid/move_col/player)
//   slave : drop engine side (drives busy/done/accepted/rejected/placed_*/board_flat/move_count/board_full)
interface column_drop_if #(
   parameter int unsigned ROWS  = 6,
   parameter int unsigned COLS  = 7,
   parameter int unsigned COL_W = 3,
   parameter int unsigned ROW_W = 3
);
   logic                     clear;
   logic                     move_valid;
   logic [COL_W-1:0]         move_col;
   logic                     player;
   logic                     busy;
   logic                     done;
   logic                     accepted;
   logic                     rejected;
   logic [ROW_W-1:0]         placed_row;
   logic [COL_W-1:0]         placed_col;
   logic [2*ROWS*COLS-1:0]   board_flat;
   logic [5:0]               move_count;
   logic                     board_full;

   modport master (
      output clear, move_valid, move_col, player,
      input  busy, done, accepted, rejected, placed_row, placed_col,
             board_flat, move_count, board_full
   );

   modport slave (
      input  clear, move_valid, move_col, player,
      output busy, done, accepted, rejected, placed_row, placed_col,
             board_flat, move_count, board_full
   );
endinterface

// File: rtl/column_drop_engine.sv
// Connect-4 column drop engine: drops the requesting player's piece into the lowest
// empty row of the selected column, one row examined per cycle, and reports the result.
//   clk, rst   : clock, asynchronous active-high reset
//   drop_if    : slave side of column_drop_if (requests in, responses/board state out)
module column_drop_engine #(
   parameter int unsigned ROWS  = 6,
   parameter int unsigned COLS  = 7,
   parameter int unsigned COL_W = 3,
   parameter int unsigned ROW_W = 3
) (
   input  logic          clk,
   input  logic          rst,
   column_drop_if.slave  drop_if
);
   localparam int unsigned CELLS   = ROWS * COLS;
   localparam int unsigned BOARD_W = 2 * CELLS;
   localparam int unsigned IDX_W   = $clog2(BOARD_W);

   typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RESP} state_e;

   state_e               state_q, state_d;
   logic [ROW_W-1:0]     row_q, row_d;
   logic [COL_W-1:0]     col_q, col_d;
   logic                 player_q, player_d;
   logic [BOARD_W-1:0]   board_q, board_d;
   logic [ROW_W-1:0]     placed_row_q, placed_row_d;
   logic [COL_W-1:0]     placed_col_q, placed_col_d;
   logic [5:0]           count_q, count_d;
   logic                 full_q, full_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 acc_q, acc_d;
   logic                 rej_q, rej_d;
   logic [IDX_W-1:0]     cell_base_c;
   logic [1:0]           cell_c;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         row_q        <= '0;
         col_q        <= '0;
         player_q     <= 1'b0;
         board_q      <= '0;
         placed_row_q <= '0;
         placed_col_q <= '0;
         count_q      <= '0;
         full_q       <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         acc_q        <= 1'b0;
         rej_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         player_q     <= player_d;
         board_q      <= board_d;
         placed_row_q <= placed_row_d;
         placed_col_q <= placed_col_d;
         count_q      <= count_d;
         full_q       <= full_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         acc_q        <= acc_d;
         rej_q        <= rej_d;
      end
   end

   // Cell currently being examined by the scan
   always_comb begin
      cell_base_c = IDX_W'(2 * (32'(row_q) * COLS + 32'(col_q)));
      cell_c      = board_q[cell_base_c +: 2];
   end

   // Next-state and response logic; response flags are set on entry to RESP
   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      player_d     = player_q;
      board_d      = board_q;
      placed_row_d = placed_row_q;
      placed_col_d = placed_col_q;
      count_d      = count_q;
      full_d       = full_q;
      done_d       = 1'b0;
      acc_d        = 1'b0;
      rej_d        = 1'b0;

      if (drop_if.clear) begin
         // New game wins over any request or in-flight move
         state_d      = ST_IDLE;
         row_d        = '0;
         board_d      = '0;
         placed_row_d = '0;
         placed_col_d = '0;
         count_d      = '0;
         full_d       = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (drop_if.move_valid) begin
                  col_d    = drop_if.move_col;
                  player_d = drop_if.player;
                  row_d    = '0;
                  if (32'(drop_if.move_col) >= COLS) begin
                     state_d = ST_RESP;
                     done_d  = 1'b1;
                     rej_d   = 1'b1;
                  end else begin
                     state_d = ST_SCAN;
                  end
               end
            end
            ST_SCAN: begin
               if (cell_c == 2'b00) begin
                  board_d[cell_base_c +: 2] = player_q ? 2'b10 : 2'b01;
                  placed_row_d = row_q;
                  placed_col_d = col_q;
                  count_d      = count_q + 6'd1;
                  full_d       = (count_q + 6'd1) == 6'(CELLS);
                  state_d      = ST_RESP;
                  done_d       = 1'b1;
                  acc_d        = 1'b1;
               end else if (row_q < ROW_W'(ROWS - 1)) begin
                  row_d = row_q + ROW_W'(1);
               end else begin
                  state_d = ST_RESP;
                  done_d  = 1'b1;
                  rej_d   = 1'b1;
               end
            end
            ST_RESP: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   assign drop_if.busy       = busy_q;
   assign drop_if.done       = done_q;
   assign drop_if.accepted   = acc_q;
   assign drop_if.rejected   = rej_q;
   assign drop_if.placed_row = placed_row_q;
   assign drop_if.placed_col = placed_col_q;
   assign drop_if.board_flat = board_q;
   assign drop_if.move_count = count_q;
   assign drop_if.board_full = full_q;
endmodule

// File: tb/tb_column_drop_engine.sv
// Directed testbench for column_drop_engine: vector table plus hand-written corner sequences.
module tb_column_drop_engine;
   logic clk;
   logic rst;
   int   total;
   int   bad;

   column_drop_if #(.ROWS(6), .COLS(7), .COL_W(3), .ROW_W(3)) drop_if ();

   column_drop_engine #(.ROWS(6), .COLS(7), .COL_W(3), .ROW_W(3)) dut (
      .clk     (clk),
      .rst     (rst),
      .drop_if (drop_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] col;
      logic       pl;
      int         lat;
      logic       acc;
      logic [2:0] row;
      logic [2:0] pcol;
      logic [5:0] cnt;
   } vec_t;

   vec_t        vecs [11];
   logic [83:0] exp_board;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic put_cell(input int r, input int c, input logic pl);
      exp_board[2*(r*7+c) +: 2] = pl ? 2'b10 : 2'b01;
   endtask

   // Issue one move and wait (bounded) for its done pulse; lat counts cycles from request
   task automatic do_move(input logic [2:0] col, input logic pl, output int lat, output logic busy1);
      drop_if.move_col   = col;
      drop_if.player     = pl;
      drop_if.move_valid = 1'b1;
      tick();
      drop_if.move_valid = 1'b0;
      busy1 = drop_if.busy;
      lat   = 1;
      while (!drop_if.done && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      int   lat;
      logic busy1;
      int   ndone;

      total = 0;
      bad   = 0;
      exp_board = '0;

      vecs[0]  = '{3'd3, 1'b0, 2, 1'b1, 3'd0, 3'd3, 6'd1};
      vecs[1]  = '{3'd3, 1'b1, 3, 1'b1, 3'd1, 3'd3, 6'd2};
      vecs[2]  = '{3'd3, 1'b0, 4, 1'b1, 3'd2, 3'd3, 6'd3};
      vecs[3]  = '{3'd3, 1'b1, 5, 1'b1, 3'd3, 3'd3, 6'd4};
      vecs[4]  = '{3'd3, 1'b0, 6, 1'b1, 3'd4, 3'd3, 6'd5};
      vecs[5]  = '{3'd3, 1'b1, 7, 1'b1, 3'd5, 3'd3, 6'd6};
      vecs[6]  = '{3'd3, 1'b0, 7, 1'b0, 3'd5, 3'd3, 6'd6};
      vecs[7]  = '{3'd7, 1'b0, 1, 1'b0, 3'd5, 3'd3, 6'd6};
      vecs[8]  = '{3'd0, 1'b1, 2, 1'b1, 3'd0, 3'd0, 6'd7};
      vecs[9]  = '{3'd6, 1'b0, 2, 1'b1, 3'd0, 3'd6, 6'd8};
      vecs[10] = '{3'd0, 1'b0, 3, 1'b1, 3'd1, 3'd0, 6'd9};

      rst                = 1'b1;
      drop_if.clear      = 1'b0;
      drop_if.move_valid = 1'b0;
      drop_if.move_col   = '0;
      drop_if.player     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy",  128'(drop_if.busy),       128'(0));
      chk("rst_done",  128'(drop_if.done),       128'(0));
      chk("rst_count", 128'(drop_if.move_count), 128'(0));
      chk("rst_board", 128'(drop_if.board_flat), 128'(0));
      chk("rst_full",  128'(drop_if.board_full), 128'(0));
      chk("rst_prow",  128'(drop_if.placed_row), 128'(0));
      rst = 1'b0;
      tick();

      // Vector table: stacking column 3, overflow, bad column, other columns
      for (int i = 0; i < 11; i++) begin
         do_move(vecs[i].col, vecs[i].pl, lat, busy1);
         if (vecs[i].acc) put_cell(int'(vecs[i].row), int'(vecs[i].col), vecs[i].pl);
         chk($sformatf("v%0d_busy", i),  128'(busy1),                128'(1));
         chk($sformatf("v%0d_lat", i),   128'(lat),                  128'(vecs[i].lat));
         chk($sformatf("v%0d_acc", i),   128'(drop_if.accepted),     128'(vecs[i].acc));
         chk($sformatf("v%0d_rej", i),   128'(drop_if.rejected),     128'(!vecs[i].acc));
         chk($sformatf("v%0d_prow", i),  128'(drop_if.placed_row),   128'(vecs[i].row));
         chk($sformatf("v%0d_pcol", i),  128'(drop_if.placed_col),   128'(vecs[i].pcol));
         chk($sformatf("v%0d_cnt", i),   128'(drop_if.move_count),   128'(vecs[i].cnt));
         chk($sformatf("v%0d_board", i), 128'(drop_if.board_flat),  128'(exp_board));
         chk($sformatf("v%0d_full", i),  128'(drop_if.board_full),   128'(0));
         tick();
         chk($sformatf("v%0d_done_off", i), 128'(drop_if.done), 128'(0));
         chk($sformatf("v%0d_busy_off", i), 128'(drop_if.busy), 128'(0));
      end

      // Request while busy is dropped: col0 has 2 pieces, pulse col2 mid-scan
      drop_if.move_col   = 3'd0;
      drop_if.player     = 1'b1;
      drop_if.move_valid = 1'b1;
      tick();
      drop_if.move_valid = 1'b0;
      tick();
      chk("busy_during_scan", 128'(drop_if.busy), 128'(1));
      drop_if.move_col   = 3'd2;
      drop_if.player     = 1'b0;
      drop_if.move_valid = 1'b1;
      tick();
      drop_if.move_valid = 1'b0;
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         if (drop_if.done) ndone++;
         tick();
      end
      put_cell(2, 0, 1'b1);
      chk("ign_ndone", 128'(ndone),              128'(1));
      chk("ign_cnt",   128'(drop_if.move_count), 128'(10));
      chk("ign_prow",  128'(drop_if.placed_row), 128'(2));
      chk("ign_board", 128'(drop_if.board_flat), 128'(exp_board));

      // Async reset mid-scan abandons the move
      drop_if.move_col   = 3'd0;
      drop_if.player     = 1'b0;
      drop_if.move_valid = 1'b1;
      tick();
      drop_if.move_valid = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("rstscan_busy",  128'(drop_if.busy),       128'(0));
      chk("rstscan_done",  128'(drop_if.done),       128'(0));
      chk("rstscan_cnt",   128'(drop_if.move_count), 128'(0));
      chk("rstscan_board", 128'(drop_if.board_flat), 128'(0));
      tick();
      rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         if (drop_if.done) ndone++;
         tick();
      end
      chk("rstscan_nodone", 128'(ndone), 128'(0));

      // Fill the whole board column by column
      exp_board = '0;
      for (int c = 0; c < 7; c++) begin
         for (int r = 0; r < 6; r++) begin
            do_move(3'(c), r[0], lat, busy1);
            put_cell(r, c, r[0]);
            chk($sformatf("fill_c%0d_r%0d", c, r), 128'({drop_if.accepted, lat[7:0]}),
                128'({1'b1, 8'(2 + r)}));
            tick();
         end
      end
      chk("full_cnt",   128'(drop_if.move_count), 128'(42));
      chk("full_flag",  128'(drop_if.board_full), 128'(1));
      chk("full_board", 128'(drop_if.board_flat), 128'(exp_board));
      do_move(3'd0, 1'b0, lat, busy1);
      chk("full_rej",     128'({drop_if.rejected, drop_if.accepted}), 128'(2'b10));
      chk("full_rej_lat", 128'(lat),                                  128'(7));
      chk("full_rej_cnt", 128'(drop_if.move_count),                   128'(42));
      tick();

      // Clear returns an empty board with no response
      drop_if.clear = 1'b1;
      tick();
      drop_if.clear = 1'b0;
      chk("clr_board", 128'(drop_if.board_flat), 128'(0));
      chk("clr_cnt",   128'(drop_if.move_count), 128'(0));
      chk("clr_full",  128'(drop_if.board_full), 128'(0));
      chk("clr_done",  128'(drop_if.done),       128'(0));
      chk("clr_prow",  128'({drop_if.placed_row, drop_if.placed_col}), 128'(0));

      // Clear and a move in the same cycle: clear wins
      do_move(3'd5, 1'b1, lat, busy1);
      chk("pre_clr_cnt", 128'(drop_if.move_count), 128'(1));
      tick();
      drop_if.clear      = 1'b1;
      drop_if.move_valid = 1'b1;
      drop_if.move_col   = 3'd4;
      drop_if.player     = 1'b0;
      tick();
      drop_if.clear      = 1'b0;
      drop_if.move_valid = 1'b0;
      chk("cm_board", 128'(drop_if.board_flat), 128'(0));
      chk("cm_cnt",   128'(drop_if.move_count), 128'(0));
      chk("cm_busy",  128'(drop_if.busy),       128'(0));
      ndone = 0;
      for (int k = 0; k < 8; k++) begin
         if (drop_if.done || drop_if.busy) ndone++;
         tick();
      end
      chk("cm_nodone", 128'(ndone),              128'(0));
      chk("cm_cnt2",   128'(drop_if.move_count), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
